// File: rtl/sha3_digest_serializer_pkg.sv
// Shared SHA-3 constants, FSM state type and the
// byte-lane reorder used by the digest datapath.
package sha3_digest_serializer_pkg;

  localparam int unsigned LANE_W         = 64;
  localparam int unsigned RATE_BYTES     = 136;
  localparam int unsigned SHA3_256_WORDS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  // Digest byte 0 sits in [7:0]; the sink wants it on [63:56].
  function automatic logic [LANE_W-1:0] lane_msb_first(
    input logic [LANE_W-1:0] lane
  );
    logic [LANE_W-1:0] r;
    r = '0;
    for (int b = 0; b < LANE_W / 8; b++) begin
      r[LANE_W-1-8*b -: 8] = lane[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha3_digest_serializer.sv
// Captures a full digest and streams it out as 64-bit
// MSB-first words over a valid/ready handshake.
module sha3_digest_serializer
  import sha3_digest_serializer_pkg::*;
#(
  parameter int unsigned DIGEST_WORDS = SHA3_256_WORDS
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [LANE_W*DIGEST_WORDS-1:0] digest_in,
  input  logic                           digest_vld,
  output logic                           digest_rdy,
  output logic [LANE_W-1:0]              data_out,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output logic                           out_last
);

  localparam int unsigned KW = $clog2(DIGEST_WORDS + 1);
  localparam logic [KW-1:0] K_LAST = KW'(DIGEST_WORDS - 1);

  ser_state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [LANE_W*DIGEST_WORDS-1:0] dig_q, dig_d;

  logic cap;
  logic xfer;
  logic [LANE_W-1:0] word_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      dig_q   <= dig_d;
    end
  end

  always_comb begin
    word_sel = '0;
    for (int i = 0; i < int'(DIGEST_WORDS); i++) begin
      if (k_q == KW'(i)) begin
        word_sel = dig_q[i*LANE_W +: LANE_W];
      end
    end
  end

  // digest_rdy depends on out_rdy and state only, never digest_vld.
  always_comb begin
    out_vld    = (state_q == SEND);
    out_last   = out_vld && (k_q == K_LAST);
    data_out   = lane_msb_first(word_sel);
    digest_rdy = (state_q == IDLE) || (out_last && out_rdy);
  end

  assign cap  = digest_vld && digest_rdy;
  assign xfer = out_vld && out_rdy;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dig_d   = dig_q;
    unique case (state_q)
      IDLE: begin
        if (cap) begin
          state_d = SEND;
          k_d     = '0;
          dig_d   = digest_in;
        end
      end
      SEND: begin
        if (xfer) begin
          if (out_last) begin
            k_d = '0;
            if (cap) begin
              dig_d = digest_in;
            end else begin
              state_d = IDLE;
            end
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

endmodule
